psum_requant_sfp: RTL and testbench

- Output-side special-function block for the systolic MAC array: consumes signed psum vectors from the array columns and accumulates a programmable number of passes per lane.
- Applies ReLU, arithmetic right shift and saturation, converting each lane back to a bw-bit unsigned activation (the format the MAC consumes on its activation input).
- Sits between the array output FIFO and activation SRAM write-back; valid/ready on both sides.

---
 rtl/psum_requant_pkg.sv | 23 ++
 rtl/sfp_lane_requant.sv | 20 ++
 rtl/psum_requant_sfp.sv | 146 ++++++++++++++
 tb/tb_psum_requant_sfp.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/psum_requant_pkg.sv
// Shared constants and types for the psum requantisation special-function block.
// Lane math runs at ACC_BW so a full group of worst-case psums cannot overflow.
package psum_requant_pkg;

  localparam int BW_DEF      = 4;
  localparam int PSUM_BW_DEF = 16;
  localparam int COL_DEF     = 8;
  localparam int PASS_BW_DEF = 4;

  localparam int ACC_BW  = PSUM_BW_DEF + PASS_BW_DEF + 1;
  localparam int ACT_MAX = (1 << BW_DEF) - 1;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Accumulator width for arbitrary parameterisations of the top.
  function automatic int acc_bw_f(input int psum_w, input int pass_w);
    return psum_w + pass_w + 1;
  endfunction

endpackage

// File: rtl/sfp_lane_requant.sv
// One lane of the output special function: ReLU, logical right shift, and
// saturation of a signed accumulated sum to an unsigned activation.
module sfp_lane_requant #(
  parameter int ACC_W = 21,
  parameter int BW    = 4
) (
  input  logic signed [ACC_W-1:0] sum_i,
  input  logic        [4:0]       shift_i,
  output logic        [BW-1:0]    act_o
);

  logic [ACC_W-1:0] relu_val;
  logic [ACC_W-1:0] shifted;

  // After ReLU the value is non-negative, so a logical shift is exact.
  assign relu_val = sum_i[ACC_W-1] ? '0 : sum_i;
  assign shifted  = relu_val >> shift_i;
  assign act_o    = (|shifted[ACC_W-1:BW]) ? '1 : shifted[BW-1:0];

endmodule

// File: rtl/psum_requant_sfp.sv
// Accumulates a programmable number of psum passes per lane, then requantises
// each lane to an unsigned activation behind a one-entry valid/ready output.
module psum_requant_sfp
  import psum_requant_pkg::*;
#(
  parameter int bw      = BW_DEF,
  parameter int psum_bw = PSUM_BW_DEF,
  parameter int col     = COL_DEF,
  parameter int pass_bw = PASS_BW_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [col*psum_bw-1:0]  in_psum,
  input  logic [pass_bw-1:0]      cfg_passes,
  input  logic [4:0]              cfg_shift,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [col*bw-1:0]       out_act,
  output logic                    busy
);

  localparam int LANE_ACC_W = acc_bw_f(psum_bw, pass_bw);
  localparam int LEN_W      = pass_bw + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = {1'b1, {pass_bw{1'b0}}};

  state_e               state_q, state_d;
  logic [pass_bw-1:0]   pass_cnt_q, pass_cnt_d;
  logic [LEN_W-1:0]     group_len_q;
  logic [4:0]           group_shift_q;
  logic [col*bw-1:0]    out_act_q;
  logic [col*bw-1:0]    act_d;

  logic                 accept;
  logic                 first_beat;
  logic                 last_beat;
  logic                 final_beat;
  logic [LEN_W-1:0]     cfg_len;
  logic [LEN_W-1:0]     len_eff;
  logic [LEN_W-1:0]     cnt_plus;
  logic [4:0]           shift_eff;

  // The first beat of a group uses the live config; later beats use the latched copy.
  assign first_beat = (pass_cnt_q == '0);
  assign cfg_len    = (cfg_passes == '0) ? LEN_MAX : {1'b0, cfg_passes};
  assign len_eff    = first_beat ? cfg_len : group_len_q;
  assign shift_eff  = first_beat ? cfg_shift : group_shift_q;
  assign cnt_plus   = {1'b0, pass_cnt_q} + LEN_W'(1);
  assign last_beat  = (cnt_plus == len_eff);
  assign accept     = in_valid && in_ready;
  assign final_beat = accept && last_beat;

  always_comb begin
    pass_cnt_d = pass_cnt_q;
    if (accept) begin
      pass_cnt_d = last_beat ? '0 : cnt_plus[pass_bw-1:0];
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC: begin
        if (final_beat) state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = final_beat ? HOLD : ACC;
      end
      default: state_d = ACC;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid = (state_q == HOLD);
    in_ready  = !out_valid || out_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_cnt_q    <= '0;
      group_len_q   <= '0;
      group_shift_q <= '0;
      out_act_q     <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      if (accept && first_beat) begin
        group_len_q   <= cfg_len;
        group_shift_q <= cfg_shift;
      end
      if (final_beat) begin
        out_act_q <= act_d;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < col; gi++) begin : g_lane
      logic signed [psum_bw-1:0]    psum_lane;
      logic signed [LANE_ACC_W-1:0] psum_ext;
      logic signed [LANE_ACC_W-1:0] sum;
      logic signed [LANE_ACC_W-1:0] acc_q;
      logic        [bw-1:0]         lane_act;

      assign psum_lane = in_psum[gi*psum_bw +: psum_bw];
      assign psum_ext  = {{(LANE_ACC_W-psum_bw){psum_lane[psum_bw-1]}}, psum_lane};
      assign sum       = first_beat ? psum_ext : (acc_q + psum_ext);

      // The last beat is consumed straight into the output register, never into acc.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          acc_q <= '0;
        end else if (accept && !last_beat) begin
          acc_q <= sum;
        end
      end

      sfp_lane_requant #(
        .ACC_W (LANE_ACC_W),
        .BW    (bw)
      ) u_lane (
        .sum_i   (sum),
        .shift_i (shift_eff),
        .act_o   (lane_act)
      );

      assign act_d[gi*bw +: bw] = lane_act;
    end
  endgenerate

  assign out_act = out_act_q;
  assign busy    = (pass_cnt_q != '0);

endmodule

// File: tb/tb_psum_requant_sfp.sv
// Directed-vector bench for psum_requant_sfp with hand-computed expectations.
module tb_psum_requant_sfp;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_psum;
  logic [3:0]   cfg_passes;
  logic [4:0]   cfg_shift;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_act;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  psum_requant_sfp dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_psum    (in_psum),
    .cfg_passes (cfg_passes),
    .cfg_shift  (cfg_shift),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_act    (out_act),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] psums(input int l0, input int l1, input int l2);
    logic [15:0] a, b, c;
    a = l0[15:0];
    b = l1[15:0];
    c = l2[15:0];
    return {80'd0, c, b, a};
  endfunction

  function automatic logic [31:0] acts(input int a0, input int a1, input int a2);
    logic [3:0] x, y, z;
    x = a0[3:0];
    y = a1[3:0];
    z = a2[3:0];
    return {20'd0, z, y, x};
  endfunction

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_psum    = '0;
    cfg_passes = 4'd1;
    cfg_shift  = 5'd0;
    out_ready  = 1'b1;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_out_act", out_act, 0);
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    check("post_reset_in_ready", in_ready, 1);

    // Single pass: 5, -3, 20 -> 5, 0, 15
    in_valid = 1'b1; cfg_passes = 4'd1; cfg_shift = 5'd0;
    in_psum  = psums(5, -3, 20);
    cycle();
    in_valid = 1'b0;
    #1;
    check("single_valid", out_valid, 1);
    check("single_act", out_act, acts(5, 0, 15));
    check("single_busy", busy, 0);
    cycle();
    check("single_drained", out_valid, 0);

    // Three-pass group with shift 2: 10+7-1 = 16 -> 4
    in_valid = 1'b1; cfg_passes = 4'd3; cfg_shift = 5'd2;
    in_psum  = psums(10, 0, 0);
    cycle();
    check("grp3_b1_busy", busy, 1);
    check("grp3_b1_valid", out_valid, 0);
    in_psum = psums(7, 0, 0);
    cycle();
    check("grp3_b2_busy", busy, 1);
    check("grp3_b2_valid", out_valid, 0);
    in_psum = psums(-1, 0, 0);
    cycle();
    check("grp3_valid", out_valid, 1);
    check("grp3_act", out_act, acts(4, 0, 0));
    check("grp3_busy", busy, 0);

    // Backpressure: result pending, next beat must wait
    out_ready = 1'b0;
    cfg_passes = 4'd1; cfg_shift = 5'd0;
    in_psum = psums(9, 0, 0);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", in_ready, 0);
      check("bp_act_stable", out_act, acts(4, 0, 0));
      check("bp_busy", busy, 0);
      cycle();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    cycle();
    check("bp_drain_valid", out_valid, 1);
    check("bp_drain_act", out_act, acts(9, 0, 0));

    // Back-to-back single-pass results, one per cycle
    for (int k = 0; k < 8; k++) begin
      in_psum = psums(k, 0, 0);
      cycle();
      check("b2b_valid", out_valid, 1);
      check("b2b_act", out_act, acts(k, 0, 0));
    end
    in_valid = 1'b0;
    cycle();
    check("b2b_end_valid", out_valid, 0);
    check("b2b_act_hold", out_act, acts(7, 0, 0));

    // Config latch: len 2 / shift 0 latched; mid-group change ignored
    in_valid = 1'b1; cfg_passes = 4'd2; cfg_shift = 5'd0;
    in_psum  = psums(3, 0, 0);
    cycle();
    check("latch_b1_busy", busy, 1);
    check("latch_b1_valid", out_valid, 0);
    cfg_passes = 4'd1; cfg_shift = 5'd1;
    in_psum = psums(4, 0, 0);
    cycle();
    check("latch_valid", out_valid, 1);
    check("latch_act", out_act, acts(7, 0, 0));
    in_valid = 1'b0;
    cycle();

    // Async reset mid-group
    in_valid = 1'b1; cfg_passes = 4'd2; cfg_shift = 5'd0;
    in_psum  = psums(6, 0, 0);
    cycle();
    in_valid = 1'b0;
    check("rst_mid_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", out_valid, 0);
    cycle();
    reset = 1'b0;
    in_valid = 1'b1; in_psum = psums(2, 0, 0);
    cycle();
    in_psum = psums(1, 0, 0);
    cycle();
    in_valid = 1'b0;
    check("rst_fresh_valid", out_valid, 1);
    check("rst_fresh_act", out_act, acts(3, 0, 0));

    // Async reset during HOLD
    out_ready = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("rst_hold_valid", out_valid, 0);
    check("rst_hold_act", out_act, 0);
    cycle();
    reset = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();
    check("rst_hold_no_emit", out_valid, 0);

    // Extremes: 16 beats of 32767 / -32768 at several shifts
    for (int r = 0; r < 3; r++) begin
      int exp0;
      cfg_passes = 4'd0;
      case (r)
        0: begin cfg_shift = 5'd31; exp0 = 0;  end
        1: begin cfg_shift = 5'd0;  exp0 = 15; end
        default: begin cfg_shift = 5'd16; exp0 = 7; end
      endcase
      in_valid = 1'b1;
      in_psum  = psums(32767, -32768, 1);
      for (int b = 0; b < 15; b++) cycle();
      check("ext_busy_b15", busy, 1);
      check("ext_valid_b15", out_valid, 0);
      cycle();
      in_valid = 1'b0;
      check("ext_valid", out_valid, 1);
      check("ext_act", out_act, acts(exp0, 0, (r == 1) ? 15 : 0));
      check("ext_busy_end", busy, 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
